// File: rtl/out_pass4_handshake_pkg.sv
// Shared definitions for the RAM_IO output-pass BEL: config-bit indices and the nibble word type.
package out_pass4_handshake_pkg;

    // Config-bit positions inside ConfigBits
    localparam int unsigned CFG_LANE_REG  = 0;   // lanes 0..3 occupy bits [3:0]
    localparam int unsigned CFG_HS_EN     = 4;
    localparam int unsigned CFG_IDLE_HOLD = 5;

    localparam int unsigned NUM_LANES     = 4;

    typedef logic [NUM_LANES-1:0] nibble_t;

    // Gather the four scalar fabric lanes into one word, lane 0 in bit 0
    function automatic nibble_t pack_lanes(input logic l0, input logic l1,
                                           input logic l2, input logic l3);
        return {l3, l2, l1, l0};
    endfunction

endpackage

// File: rtl/out_pass4_handshake_fifo2.sv
// Building blocks for the output-pass BEL: a small nibble FIFO and a per-lane 2:1 mux.
module out_fifo2
    import out_pass4_handshake_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic                          push,
    input  nibble_t                       din,
    input  logic                          pop,
    output nibble_t                       dout,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    nibble_t            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];

    // A full FIFO refuses writes even when a read happens in the same cycle
    assign w_push = push & ~full;
    assign w_pop  = pop  & ~empty;

    // Storage, pointers and occupancy; flush empties the buffer without touching storage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// Simple 2:1 selector used per lane to pick combinational or registered pass data.
module my_mux2 (
    input  logic A0,
    input  logic A1,
    input  logic S,
    output logic X
);

    assign X = S ? A1 : A0;

endmodule

// File: rtl/out_pass4_handshake.sv
// Fabric-to-pad output BEL: four-lane pass-through or a buffered nibble valid/ready channel.
module out_pass4_handshake
    import out_pass4_handshake_pkg::*;
#(
    parameter int unsigned NoConfigBits = 6,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic                    UserCLK,
    input  logic                    RESETn,
    input  logic                    I0,
    input  logic                    I1,
    input  logic                    I2,
    input  logic                    I3,
    input  logic                    I_VALID,
    output logic                    I_READY,
    output logic                    O0,
    output logic                    O1,
    output logic                    O2,
    output logic                    O3,
    output logic                    O_VALID,
    input  logic                    O_READY,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    nibble_t            r_q;
    nibble_t            r_last;
    nibble_t            w_in;
    nibble_t            w_pass;
    nibble_t            w_hs_data;
    nibble_t            w_out;
    nibble_t            w_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_hs_en;
    logic               w_idle_hold;
    logic               w_push;
    logic               w_pop;

    assign w_in        = pack_lanes(I0, I1, I2, I3);
    assign w_hs_en     = ConfigBits[CFG_HS_EN];
    assign w_idle_hold = ConfigBits[CFG_IDLE_HOLD];

    // Lane flops sample the fabric every cycle regardless of mode
    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            r_q <= '0;
        end else begin
            r_q <= w_in;
        end
    end

    // Per-lane combinational/registered selection for pass mode
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        my_mux2 u_mux (
            .A0 (w_in[g]),
            .A1 (r_q[g]),
            .S  (ConfigBits[CFG_LANE_REG + g]),
            .X  (w_pass[g])
        );
    end

    // Handshake glue; both flags depend on occupancy only and are forced idle in pass mode
    assign I_READY = ~w_hs_en | (w_count != CNT_W'(FIFO_DEPTH));
    assign O_VALID = w_hs_en & ~w_empty;
    assign w_push  = w_hs_en & I_VALID & ~w_full;
    assign w_pop   = O_VALID & O_READY;

    out_fifo2 #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (UserCLK),
        .resetn (RESETn),
        .flush  (~w_hs_en),
        .push   (w_push),
        .din    (w_in),
        .pop    (w_pop),
        .dout   (w_head),
        .count  (w_count),
        .full   (w_full),
        .empty  (w_empty)
    );

    // Last popped word, kept across mode switches for the idle-hold display
    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            r_last <= '0;
        end else if (w_pop) begin
            r_last <= w_head;
        end
    end

    assign w_hs_data = O_VALID     ? w_head :
                       w_idle_hold ? r_last : '0;

    assign w_out = w_hs_en ? w_hs_data : w_pass;

    assign O0 = w_out[0];
    assign O1 = w_out[1];
    assign O2 = w_out[2];
    assign O3 = w_out[3];

endmodule

// File: tb/tb_out_pass4_handshake.sv
// Directed bench for out_pass4_handshake: pass mode, handshake buffering, reset and mode switch.
module tb_out_pass4_handshake;

    logic       UserCLK = 1'b0;
    logic       RESETn;
    logic       I0, I1, I2, I3;
    logic       I_VALID;
    logic       I_READY;
    logic       O0, O1, O2, O3;
    logic       O_VALID;
    logic       O_READY;
    logic [5:0] ConfigBits;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [3:0] q_model[$];
    logic [3:0] last_model;

    out_pass4_handshake #(
        .NoConfigBits (6),
        .FIFO_DEPTH   (2)
    ) dut (
        .UserCLK    (UserCLK),
        .RESETn     (RESETn),
        .I0         (I0),
        .I1         (I1),
        .I2         (I2),
        .I3         (I3),
        .I_VALID    (I_VALID),
        .I_READY    (I_READY),
        .O0         (O0),
        .O1         (O1),
        .O2         (O2),
        .O3         (O3),
        .O_VALID    (O_VALID),
        .O_READY    (O_READY),
        .ConfigBits (ConfigBits)
    );

    always #5 UserCLK = ~UserCLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    task automatic set_in(input logic [3:0] d);
        {I3, I2, I1, I0} = d;
    endtask

    function automatic logic [3:0] o_word();
        return {O3, O2, O1, O0};
    endfunction

    // {I_READY, O_VALID, O3..O0}
    function automatic logic [7:0] status();
        return {2'b00, I_READY, O_VALID, O3, O2, O1, O0};
    endfunction

    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESETn     = 1'b0;
        ConfigBits = 6'b000101;
        set_in(4'h0);
        I_VALID    = 1'b0;
        O_READY    = 1'b0;
        last_model = 4'h0;
        #12;
        check("reset_status", status(), {2'b00, 1'b1, 1'b0, 4'h0});
        @(negedge UserCLK);
        RESETn = 1'b1;
        tick();

        // ---- 1: pass mode, lanes 0 and 2 registered ----
        set_in(4'hF);
        I_VALID = 1'b1;
        O_READY = 1'b1;
        #1;
        check("pass_comb_lanes", status(), {2'b00, 1'b1, 1'b0, 4'b1010});
        tick();
        check("pass_reg_lanes", status(), {2'b00, 1'b1, 1'b0, 4'b1111});
        set_in(4'h0);
        #1;
        check("pass_fall_comb", status(), {2'b00, 1'b1, 1'b0, 4'b0101});
        tick();
        check("pass_fall_reg", status(), {2'b00, 1'b1, 1'b0, 4'b0000});

        // ---- 2: handshake, consumer stalled ----
        I_VALID    = 1'b0;
        O_READY    = 1'b0;
        ConfigBits = 6'b010000;
        #1;
        check("hs_idle", status(), {2'b00, 1'b1, 1'b0, 4'h0});
        I_VALID = 1'b1;
        set_in(4'hA);
        tick();
        check("hs_push_a", status(), {2'b00, 1'b1, 1'b1, 4'hA});
        set_in(4'h5);
        tick();
        check("hs_full", status(), {2'b00, 1'b0, 1'b1, 4'hA});
        set_in(4'h3);
        tick();
        check("hs_push_while_full", status(), {2'b00, 1'b0, 1'b1, 4'hA});
        I_VALID = 1'b0;

        // ---- 3: drain ----
        O_READY = 1'b1;
        tick();
        check("hs_pop_a", status(), {2'b00, 1'b1, 1'b1, 4'h5});
        tick();
        O_READY = 1'b0;
        #1;
        check("hs_empty_nohold", status(), {2'b00, 1'b1, 1'b0, 4'h0});
        ConfigBits = 6'b110000;
        #1;
        check("hs_empty_hold", status(), {2'b00, 1'b1, 1'b0, 4'h5});

        // ---- 4: simultaneous push and pop at count 1 ----
        I_VALID = 1'b1;
        set_in(4'h7);
        tick();
        set_in(4'h9);
        O_READY = 1'b1;
        #1;
        check("hs_pre_pushpop", status(), {2'b00, 1'b1, 1'b1, 4'h7});
        tick();
        I_VALID = 1'b0;
        O_READY = 1'b0;
        #1;
        check("hs_after_pushpop", status(), {2'b00, 1'b1, 1'b1, 4'h9});
        O_READY = 1'b1;
        tick();
        O_READY = 1'b0;
        #1;
        check("hs_pop_9", status(), {2'b00, 1'b1, 1'b0, 4'h9});
        last_model = 4'h9;

        // 16 random streams against a queue model
        for (int s = 0; s < 16; s++) begin
            int unsigned pushed = 0;
            int unsigned cycles = 0;
            while ((pushed < 6 || q_model.size() != 0) && cycles < 100) begin
                logic       iv;
                logic       ordy;
                logic [3:0] d;
                logic       exp_v;
                logic       exp_r;
                logic       was_full;
                logic [3:0] exp_o;
                iv   = (pushed < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
                d    = 4'($urandom_range(0, 15));
                ordy = 1'($urandom_range(0, 1));
                I_VALID = iv;
                O_READY = ordy;
                set_in(d);
                #1;
                exp_v    = (q_model.size() != 0);
                was_full = (q_model.size() == 2);
                exp_r    = ~was_full;
                exp_o    = last_model;
                if (exp_v) exp_o = q_model[0];
                check($sformatf("stream%0d", s), status(), {2'b00, exp_r, exp_v, exp_o});
                if (exp_v && ordy) last_model = q_model.pop_front();
                if (iv && !was_full) begin
                    q_model.push_back(d);
                    pushed++;
                end
                tick();
                cycles++;
            end
            check($sformatf("stream%0d_done", s), 8'(cycles < 100), 8'd1);
        end
        I_VALID = 1'b0;
        O_READY = 1'b0;

        // ---- 5: async reset with two words buffered ----
        I_VALID = 1'b1;
        set_in(4'h1);
        tick();
        set_in(4'h2);
        tick();
        I_VALID = 1'b0;
        #1;
        check("rst_pre_full", status(), {2'b00, 1'b0, 1'b1, 4'h1});
        #1;
        RESETn = 1'b0;
        #1;
        check("rst_async", status(), {2'b00, 1'b1, 1'b0, 4'h0});
        @(negedge UserCLK);
        RESETn = 1'b1;
        I_VALID = 1'b1;
        set_in(4'hC);
        #1;
        check("rst_release_empty", status(), {2'b00, 1'b1, 1'b0, 4'h0});
        tick();
        I_VALID = 1'b0;
        #1;
        check("rst_first_push", status(), {2'b00, 1'b1, 1'b1, 4'hC});
        O_READY = 1'b1;
        tick();
        O_READY = 1'b0;
        #1;
        check("rst_pop_c", status(), {2'b00, 1'b1, 1'b0, 4'hC});

        // ---- 6: mode toggle drops buffered words ----
        I_VALID = 1'b1;
        set_in(4'h3);
        tick();
        set_in(4'h4);
        tick();
        I_VALID = 1'b0;
        ConfigBits = 6'b100000;
        tick();
        ConfigBits = 6'b110000;
        #1;
        check("mode_flush", status(), {2'b00, 1'b1, 1'b0, 4'hC});
        O_READY = 1'b1;
        tick();
        check("mode_no_old_words", status(), {2'b00, 1'b1, 1'b0, 4'hC});
        O_READY = 1'b0;
        I_VALID = 1'b1;
        set_in(4'h6);
        tick();
        I_VALID = 1'b0;
        #1;
        check("mode_fresh_push", status(), {2'b00, 1'b1, 1'b1, 4'h6});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
